// File: rtl/score_keeper.sv
// score_keeper: Pong-style score keeping and serve sequencing.
//
// Watches the ball position once per frame. It detects a miss on the left
// side (player) or the right side (computer) and keeps both scores. It holds
// the ball for PAUSE_FRAMES frames between points, then issues a one-cycle
// serve. It declares the winner when a side reaches WIN_SCORE.
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-low reset
//   new_frame_i     one-cycle strobe per display frame
//   ball_x_i        ball left-edge x position
//   restart_i       one-cycle restart request
//   player_score_o  player (left) points
//   pc_score_o      computer (right) points
//   hold_o          freeze ball motion in the game logic
//   serve_o         one-cycle pulse: re-centre and launch the ball
//   serve_dir_o     launch direction, 0 = left (toward player), 1 = right
//   game_over_o     match finished
//   winner_o        valid with game_over_o, 0 = player, 1 = computer
module score_keeper #(
  parameter int unsigned X_POS_W      = 10,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned PAUSE_W      = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               new_frame_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  input  logic               restart_i,
  output logic [SCORE_W-1:0] player_score_o,
  output logic [SCORE_W-1:0] pc_score_o,
  output logic               hold_o,
  output logic               serve_o,
  output logic               serve_dir_o,
  output logic               game_over_o,
  output logic               winner_o
);

  localparam int unsigned XW = X_POS_W + 1;

  localparam logic [XW-1:0]      BallSz    = XW'(BALL_SIZE);
  localparam logic [XW-1:0]      ScreenW   = XW'(SCREEN_W);
  localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);
  localparam logic [PAUSE_W-1:0] PauseLoad = PAUSE_W'(PAUSE_FRAMES);
  localparam logic [PAUSE_W-1:0] PauseOne  = PAUSE_W'(1);

  typedef enum logic [1:0] {
    StPlay  = 2'd0,
    StPause = 2'd1,
    StOver  = 2'd2
  } state_e;

  state_e               state_q;
  logic [PAUSE_W-1:0]   pause_cnt_q;
  logic [SCORE_W-1:0]   player_score_q;
  logic [SCORE_W-1:0]   pc_score_q;
  logic                 hold_q;
  logic                 serve_q;
  logic                 serve_dir_q;
  logic                 game_over_q;
  logic                 winner_q;

  logic                 left_miss;
  logic                 right_miss;
  logic [SCORE_W-1:0]   player_inc;
  logic [SCORE_W-1:0]   pc_inc;

  // Right edge test is done one bit wider so ball_x_i + BALL_SIZE cannot wrap.
  always_comb begin
    left_miss  = (ball_x_i == '0);
    right_miss = (({1'b0, ball_x_i} + BallSz) >= ScreenW);
    player_inc = player_score_q + ScoreOne;
    pc_inc     = pc_score_q + ScoreOne;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= StPause;
      pause_cnt_q    <= PauseLoad;
      player_score_q <= '0;
      pc_score_q     <= '0;
      hold_q         <= 1'b1;
      serve_q        <= 1'b0;
      serve_dir_q    <= 1'b1;
      game_over_q    <= 1'b0;
      winner_q       <= 1'b0;
    end else begin
      // Serve is a single-cycle pulse unless re-asserted below.
      serve_q <= 1'b0;
      if (restart_i) begin
        // Direction is kept so the next serve goes the same way as before.
        state_q        <= StPause;
        pause_cnt_q    <= PauseLoad;
        player_score_q <= '0;
        pc_score_q     <= '0;
        hold_q         <= 1'b1;
        game_over_q    <= 1'b0;
        winner_q       <= 1'b0;
      end else begin
        unique case (state_q)
          StPlay: begin
            if (new_frame_i) begin
              // Left miss takes precedence when both edges trigger.
              if (left_miss) begin
                pc_score_q  <= pc_inc;
                serve_dir_q <= 1'b0;
                hold_q      <= 1'b1;
                if (pc_inc == WinScore) begin
                  state_q     <= StOver;
                  game_over_q <= 1'b1;
                  winner_q    <= 1'b1;
                end else begin
                  state_q     <= StPause;
                  pause_cnt_q <= PauseLoad;
                end
              end else if (right_miss) begin
                player_score_q <= player_inc;
                serve_dir_q    <= 1'b1;
                hold_q         <= 1'b1;
                if (player_inc == WinScore) begin
                  state_q     <= StOver;
                  game_over_q <= 1'b1;
                  winner_q    <= 1'b0;
                end else begin
                  state_q     <= StPause;
                  pause_cnt_q <= PauseLoad;
                end
              end
            end
          end
          StPause: begin
            if (new_frame_i) begin
              if (pause_cnt_q == PauseOne) begin
                state_q     <= StPlay;
                serve_q     <= 1'b1;
                hold_q      <= 1'b0;
                pause_cnt_q <= PauseLoad;
              end else begin
                pause_cnt_q <= pause_cnt_q - PauseOne;
              end
            end
          end
          StOver: begin
            // Match finished; only restart_i or reset leave this state.
            hold_q <= 1'b1;
          end
          default: begin
            state_q <= StPause;
          end
        endcase
      end
    end
  end

  assign player_score_o = player_score_q;
  assign pc_score_o     = pc_score_q;
  assign hold_o         = hold_q;
  assign serve_o        = serve_q;
  assign serve_dir_o    = serve_dir_q;
  assign game_over_o    = game_over_q;
  assign winner_o       = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed plus random stimulus against a frame-level
// reference model of the scoring rules.
module tb_score_keeper;

  localparam int SCREEN_W     = 640;
  localparam int BALL_SIZE    = 8;
  localparam int WIN_SCORE    = 7;
  localparam int PAUSE_FRAMES = 60;

  logic       clk;
  logic       rst_n;
  logic       new_frame;
  logic [9:0] ball_x;
  logic       restart;
  logic [3:0] player_score;
  logic [3:0] pc_score;
  logic       hold;
  logic       serve;
  logic       serve_dir;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = playing, 1 = waiting to serve, 2 = match over.
  int m_player, m_pc, m_phase, m_frames_left;
  bit m_serve, m_dir, m_over, m_winner;

  score_keeper dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .new_frame_i   (new_frame),
    .ball_x_i      (ball_x),
    .restart_i     (restart),
    .player_score_o(player_score),
    .pc_score_o    (pc_score),
    .hold_o        (hold),
    .serve_o       (serve),
    .serve_dir_o   (serve_dir),
    .game_over_o   (game_over),
    .winner_o      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_player = 0; m_pc = 0; m_phase = 1; m_frames_left = PAUSE_FRAMES;
    m_serve = 0; m_dir = 1; m_over = 0; m_winner = 0;
  endtask

  task automatic award(input bit to_pc);
    int s;
    if (to_pc) begin m_pc++; s = m_pc; m_dir = 0; end
    else begin m_player++; s = m_player; m_dir = 1; end
    if (s == WIN_SCORE) begin
      m_phase = 2; m_over = 1; m_winner = to_pc;
    end else begin
      m_phase = 1; m_frames_left = PAUSE_FRAMES;
    end
  endtask

  task automatic model_step(input bit nf, input int x, input bit rs);
    m_serve = 0;
    if (rs) begin
      m_player = 0; m_pc = 0; m_over = 0; m_winner = 0;
      m_phase = 1; m_frames_left = PAUSE_FRAMES;
    end else if (m_phase == 0 && nf) begin
      if (x == 0) award(1'b1);
      else if (x + BALL_SIZE >= SCREEN_W) award(1'b0);
    end else if (m_phase == 1 && nf) begin
      m_frames_left--;
      if (m_frames_left == 0) begin
        m_serve = 1; m_phase = 0;
      end
    end
  endtask

  task automatic check_all();
    check("player_score", int'(player_score), m_player);
    check("pc_score", int'(pc_score), m_pc);
    check("hold", int'(hold), (m_phase != 0) ? 1 : 0);
    check("serve", int'(serve), int'(m_serve));
    check("serve_dir", int'(serve_dir), int'(m_dir));
    check("game_over", int'(game_over), int'(m_over));
    check("winner", int'(winner), int'(m_winner));
  endtask

  task automatic step(input bit nf, input int x, input bit rs);
    @(negedge clk);
    new_frame = nf; ball_x = 10'(x); restart = rs;
    @(posedge clk);
    model_step(nf, x, rs);
    #1;
    check_all();
  endtask

  // Strobe frames until the serve pulse; bounded so a missing serve cannot hang.
  task automatic run_to_serve(input int x);
    int n = 0;
    do begin
      step(1'b1, x, 1'b0);
      n++;
    end while (serve !== 1'b1 && n < PAUSE_FRAMES + 5);
    check("serve_after_frames", n, PAUSE_FRAMES);
  endtask

  initial begin
    rst_n = 1'b0; new_frame = 1'b0; ball_x = 10'd300; restart = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // First serve after 60 strobes, with idle cycles interleaved.
    for (int i = 0; i < PAUSE_FRAMES; i++) begin
      step(1'b1, 300, 1'b0);
      if (i < PAUSE_FRAMES - 1) begin
        check("hold_during_pause", int'(hold), 1);
        step(1'b0, 300, 1'b0);
      end
    end
    check("first_serve", int'(serve), 1);
    check("first_serve_dir", int'(serve_dir), 1);
    check("first_serve_hold", int'(hold), 0);
    step(1'b0, 300, 1'b0);
    check("serve_one_cycle", int'(serve), 0);

    // Left miss, then repeated misses during the pause score nothing.
    step(1'b1, 0, 1'b0);
    check("left_miss_pc", int'(pc_score), 1);
    check("left_miss_hold", int'(hold), 1);
    check("left_miss_dir", int'(serve_dir), 0);
    run_to_serve(0);
    check("no_rescore", int'(pc_score), 1);

    // Right edge boundary: 631 is in play, 632 touches the wall.
    step(1'b1, 631, 1'b0);
    check("x631_no_score", int'(player_score), 0);
    step(1'b1, 632, 1'b0);
    check("x632_player", int'(player_score), 1);
    check("x632_dir", int'(serve_dir), 1);

    // Player wins.
    for (int p = 2; p <= WIN_SCORE; p++) begin
      run_to_serve(300);
      step(1'b1, 700, 1'b0);
    end
    check("win_player_score", int'(player_score), WIN_SCORE);
    check("win_game_over", int'(game_over), 1);
    check("win_winner", int'(winner), 0);
    check("win_hold", int'(hold), 1);
    for (int i = 0; i < 70; i++) step(1'b1, 0, 1'b0);
    check("over_frozen", int'(player_score), WIN_SCORE);

    // Restart coincident with a strobe.
    step(1'b1, 0, 1'b1);
    check("restart_player", int'(player_score), 0);
    check("restart_over", int'(game_over), 0);
    run_to_serve(300);

    // Reset asserted on the strobe where a serve is due.
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < PAUSE_FRAMES - 1; i++) step(1'b1, 300, 1'b0);
    @(negedge clk);
    new_frame = 1'b1; rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check("reset_cancels_serve", int'(serve), 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1; new_frame = 1'b0;
    run_to_serve(300);

    // Random play.
    for (int i = 0; i < 8000; i++) begin
      int r, x;
      r = int'($urandom_range(0, 7));
      case (r)
        0: x = 0;
        1: x = int'($urandom_range(632, 1023));
        2: x = 631;
        default: x = int'($urandom_range(1, 631));
      endcase
      step(($urandom_range(0, 3) != 0), x, ($urandom_range(0, 399) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
